execute_stage_param: RTL and testbench

Parametrised Y86-64 execute stage with its E-to-M pipeline register, generalised in datapath width and with optional extended ALU ops. It takes decoded E-register fields, computes the ALU result, holds the condition-code register and evaluates jXX/cmovXX conditions. It drives the forwarding taps (e_valE, e_dstE, e_Cnd) and registers results into M under stall/bubble control. Sits between decode_wb and the memory stage.

---
 rtl/execute_stage_param.sv | 197 +++++++++++++++++++
 tb/tb_execute_stage_param.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage_param.sv
// Y86-64 execute stage with its E-to-M pipeline register, parametrised in datapath width.
//
// Computes the ALU result for the instruction in E, holds the {ZF,SF,OF} condition codes and
// evaluates jXX/cmovXX conditions against the codes as they stood before this cycle's update.
// The e_* outputs are combinational forwarding taps; the M_* outputs are the registered
// E-to-M pipeline stage.
//
// Parameters:
//   WIDTH      - datapath width of valC/valA/valB/valE
//   EXT_OPS    - 1 adds OPq ifun 4 (mulq, low WIDTH bits) and ifun 5 (orq)
//   STACK_STEP - stack pointer adjust for call/push/ret/pop
//
// Ports:
//   clk, reset           - clock; synchronous active-high reset
//   E_*                  - decoded fields of the instruction in E
//   set_cc               - permission to write the condition codes
//   M_stall, M_bubble    - hold / load-NOP control for the M register (stall wins)
//   M_*                  - registered E-to-M pipeline outputs
//   e_valE, e_dstE, e_Cnd - combinational forwarding taps
//   cc                   - {ZF,SF,OF} condition-code register
module execute_stage_param #(
    parameter int unsigned WIDTH      = 64,
    parameter bit          EXT_OPS    = 1'b0,
    parameter int unsigned STACK_STEP = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       E_stat,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_ifun,
    input  logic [WIDTH-1:0] E_valC,
    input  logic [WIDTH-1:0] E_valA,
    input  logic [WIDTH-1:0] E_valB,
    input  logic [3:0]       E_dstE,
    input  logic [3:0]       E_dstM,
    input  logic             set_cc,
    input  logic             M_stall,
    input  logic             M_bubble,
    output logic [1:0]       M_stat,
    output logic [3:0]       M_icode,
    output logic             M_Cnd,
    output logic [WIDTH-1:0] M_valE,
    output logic [WIDTH-1:0] M_valA,
    output logic [3:0]       M_dstE,
    output logic [3:0]       M_dstM,
    output logic [WIDTH-1:0] e_valE,
    output logic [3:0]       e_dstE,
    output logic             e_Cnd,
    output logic [2:0]       cc
);

    localparam logic [3:0] INop    = 4'h1;
    localparam logic [3:0] IRrmovq = 4'h2;
    localparam logic [3:0] IIrmovq = 4'h3;
    localparam logic [3:0] IRmmovq = 4'h4;
    localparam logic [3:0] IMrmovq = 4'h5;
    localparam logic [3:0] IOpq    = 4'h6;
    localparam logic [3:0] IJxx    = 4'h7;
    localparam logic [3:0] ICall   = 4'h8;
    localparam logic [3:0] IRet    = 4'h9;
    localparam logic [3:0] IPushq  = 4'hA;
    localparam logic [3:0] IPopq   = 4'hB;
    localparam logic [3:0] RNone   = 4'hF;
    localparam logic [1:0] SAok    = 2'd0;
    localparam logic [1:0] SIns    = 2'd3;

    localparam logic [WIDTH-1:0] StepPos = WIDTH'(STACK_STEP);
    localparam logic [WIDTH-1:0] StepNeg = ~StepPos + {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]   alu_a, alu_b, sum, diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     prod_top;
    logic [WIDTH-1:0]   alu_out;
    logic               alu_of, op_valid, is_op, cc_write, cond;
    logic               zf, sf, of_flag;
    logic [1:0]         e_stat;

    always_comb begin
        alu_a = '0;
        case (E_icode)
            IRrmovq, IOpq:             alu_a = E_valA;
            IIrmovq, IRmmovq, IMrmovq: alu_a = E_valC;
            ICall, IPushq:             alu_a = StepNeg;
            IRet, IPopq:               alu_a = StepPos;
            default:                   alu_a = '0;
        endcase
    end

    always_comb begin
        alu_b = '0;
        case (E_icode)
            IRmmovq, IMrmovq, IOpq, ICall, IRet, IPushq, IPopq: alu_b = E_valB;
            default:                                            alu_b = '0;
        endcase
    end

    assign sum  = alu_a + alu_b;
    assign diff = alu_b - alu_a;
    // Sign-extend both operands so the low 2*WIDTH bits hold the exact signed product.
    assign prod = {{WIDTH{alu_a[WIDTH-1]}}, alu_a} * {{WIDTH{alu_b[WIDTH-1]}}, alu_b};
    // Product fits in WIDTH bits iff its upper half plus the WIDTH-1 bit are all-equal.
    assign prod_top = prod[2*WIDTH-1:WIDTH-1];

    assign is_op = (E_icode == IOpq);

    always_comb begin
        alu_out  = sum;
        alu_of   = 1'b0;
        op_valid = 1'b1;
        if (is_op) begin
            case (E_ifun)
                4'h0: begin
                    alu_out = sum;
                    alu_of  = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) &&
                              (sum[WIDTH-1] != alu_a[WIDTH-1]);
                end
                4'h1: begin
                    alu_out = diff;
                    alu_of  = (alu_b[WIDTH-1] != alu_a[WIDTH-1]) &&
                              (diff[WIDTH-1] != alu_b[WIDTH-1]);
                end
                4'h2: alu_out = alu_a & alu_b;
                4'h3: alu_out = alu_a ^ alu_b;
                4'h4: begin
                    if (EXT_OPS) begin
                        alu_out = prod[WIDTH-1:0];
                        alu_of  = !((&prod_top) || !(|prod_top));
                    end else begin
                        op_valid = 1'b0;
                    end
                end
                4'h5: begin
                    if (EXT_OPS) alu_out = alu_a | alu_b;
                    else         op_valid = 1'b0;
                end
                default: op_valid = 1'b0;
            endcase
            if (!op_valid) begin
                alu_out = '0;
                alu_of  = 1'b0;
            end
        end
    end

    assign e_valE   = alu_out;
    assign cc_write = set_cc && is_op && op_valid;

    assign {zf, sf, of_flag} = cc;

    always_comb begin
        cond = 1'b0;
        case (E_ifun)
            4'h0:    cond = 1'b1;
            4'h1:    cond = (sf ^ of_flag) | zf;
            4'h2:    cond = sf ^ of_flag;
            4'h3:    cond = zf;
            4'h4:    cond = !zf;
            4'h5:    cond = !(sf ^ of_flag);
            4'h6:    cond = !(sf ^ of_flag) && !zf;
            default: cond = 1'b0;
        endcase
    end

    assign e_Cnd  = ((E_icode == IRrmovq) || (E_icode == IJxx)) ? cond : 1'b0;
    // A cmov that is not taken must not write its destination.
    assign e_dstE = ((E_icode == IRrmovq) && !e_Cnd) ? RNone : E_dstE;
    assign e_stat = (is_op && !op_valid && (E_stat == SAok)) ? SIns : E_stat;

    always_ff @(posedge clk) begin
        if (reset) begin
            cc <= 3'b100;
        end else if (cc_write) begin
            cc <= {(alu_out == '0), alu_out[WIDTH-1], alu_of};
        end
    end

    always_ff @(posedge clk) begin
        if (reset || (M_bubble && !M_stall)) begin
            M_stat  <= SAok;
            M_icode <= INop;
            M_Cnd   <= 1'b0;
            M_valE  <= '0;
            M_valA  <= '0;
            M_dstE  <= RNone;
            M_dstM  <= RNone;
        end else if (!M_stall) begin
            M_stat  <= e_stat;
            M_icode <= E_icode;
            M_Cnd   <= e_Cnd;
            M_valE  <= e_valE;
            M_valA  <= E_valA;
            M_dstE  <= e_dstE;
            M_dstM  <= E_dstM;
        end
    end

endmodule

// File: tb/tb_execute_stage_param.sv
module tb_execute_stage_param;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  E_stat;
    logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM;
    logic [63:0] E_valC, E_valA, E_valB;
    logic        set_cc, M_stall, M_bubble;

    logic [1:0]  m_stat64, m_stat32;
    logic [3:0]  m_icode64, m_icode32, m_dste64, m_dste32, m_dstm64, m_dstm32;
    logic        m_cnd64, m_cnd32, e_cnd64, e_cnd32;
    logic [63:0] m_vale64, m_vala64, e_vale64;
    logic [31:0] m_vale32, m_vala32, e_vale32;
    logic [3:0]  e_dste64, e_dste32;
    logic [2:0]  cc64, cc32;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    execute_stage_param dut64 (
        .clk(clk), .reset(reset), .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
        .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB), .E_dstE(E_dstE), .E_dstM(E_dstM),
        .set_cc(set_cc), .M_stall(M_stall), .M_bubble(M_bubble),
        .M_stat(m_stat64), .M_icode(m_icode64), .M_Cnd(m_cnd64), .M_valE(m_vale64),
        .M_valA(m_vala64), .M_dstE(m_dste64), .M_dstM(m_dstm64),
        .e_valE(e_vale64), .e_dstE(e_dste64), .e_Cnd(e_cnd64), .cc(cc64)
    );

    execute_stage_param #(.WIDTH(32), .EXT_OPS(1'b1), .STACK_STEP(8)) dut32 (
        .clk(clk), .reset(reset), .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
        .E_valC(E_valC[31:0]), .E_valA(E_valA[31:0]), .E_valB(E_valB[31:0]),
        .E_dstE(E_dstE), .E_dstM(E_dstM),
        .set_cc(set_cc), .M_stall(M_stall), .M_bubble(M_bubble),
        .M_stat(m_stat32), .M_icode(m_icode32), .M_Cnd(m_cnd32), .M_valE(m_vale32),
        .M_valA(m_vala32), .M_dstE(m_dste32), .M_dstM(m_dstm32),
        .e_valE(e_vale32), .e_dstE(e_dste32), .e_Cnd(e_cnd32), .cc(cc32)
    );

    typedef struct {
        string       name;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] val_a;
        logic [63:0] val_b;
        logic [63:0] val_c;
        logic [3:0]  dst_e;
        logic        set_cc;
        logic [63:0] exp_val_e;
        logic [3:0]  exp_dst_e;
        logic        exp_cnd;
        logic [2:0]  exp_cc;
        logic [1:0]  exp_stat;
    } vec_t;

    function automatic vec_t mk(input string name, input logic [3:0] icode, input logic [3:0] ifun,
                                input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                                input logic [3:0] dst, input logic scc, input logic [63:0] ev,
                                input logic [3:0] ed, input logic cnd, input logic [2:0] ecc,
                                input logic [1:0] st);
        vec_t v;
        v.name = name; v.icode = icode; v.ifun = ifun; v.val_a = a; v.val_b = b; v.val_c = c;
        v.dst_e = dst; v.set_cc = scc; v.exp_val_e = ev; v.exp_dst_e = ed; v.exp_cnd = cnd;
        v.exp_cc = ecc; v.exp_stat = st;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_e(input logic [3:0] icode, input logic [3:0] ifun, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] c, input logic [3:0] dst,
                         input logic scc);
        E_icode = icode; E_ifun = ifun; E_valA = a; E_valB = b; E_valC = c;
        E_dstE = dst; set_cc = scc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [63:0] Q4 = 64'h4000_0000_0000_0000;
    localparam logic [63:0] Q8 = 64'h8000_0000_0000_0000;

    vec_t vecs[$];

    initial begin
        // Ordered: cc carries from one vector to the next. cc after reset is 3'b100.
        vecs.push_back(mk("subq_eq",   6, 1, 5, 5, 0, 2, 1, 0, 2, 0, 3'b100, 0));
        vecs.push_back(mk("cmovle_z",  2, 1, 64'h77, 0, 0, 3, 0, 64'h77, 3, 1, 3'b100, 0));
        vecs.push_back(mk("addq_ovf",  6, 0, Q4, Q4, 0, 2, 1, Q8, 2, 0, 3'b011, 0));
        // SF=OF=1: true sum is positive, so g is taken and l is not.
        vecs.push_back(mk("jg_ovf",    7, 6, 0, 0, 64'h1234, 4'hF, 0, 0, 4'hF, 1, 3'b011, 0));
        vecs.push_back(mk("jl_ovf",    7, 2, 0, 0, 64'h1234, 4'hF, 0, 0, 4'hF, 0, 3'b011, 0));
        vecs.push_back(mk("andq_z",    6, 2, 64'hF0, 64'h0F, 0, 2, 1, 0, 2, 0, 3'b100, 0));
        vecs.push_back(mk("cmovne_nt", 2, 4, 9, 0, 0, 4, 0, 9, 4'hF, 0, 3'b100, 0));
        vecs.push_back(mk("pushq",     4'hA, 0, 0, 64'h100, 0, 4, 0, 64'hF8, 4, 0, 3'b100, 0));
        vecs.push_back(mk("popq",      4'hB, 0, 0, 64'h100, 0, 4, 0, 64'h108, 4, 0, 3'b100, 0));
        vecs.push_back(mk("xorq_nocc", 6, 3, 64'hFF, 64'h0F, 0, 2, 0, 64'hF0, 2, 0, 3'b100, 0));
        vecs.push_back(mk("subq_neg",  6, 1, 1, 0, 0, 2, 1, '1, 2, 0, 3'b010, 0));
        vecs.push_back(mk("subq_ovf",  6, 1, 1, Q8, 0, 2, 1, 64'h7FFF_FFFF_FFFF_FFFF, 2, 0,
                          3'b001, 0));
        vecs.push_back(mk("cmovle_of", 2, 1, 5, 0, 0, 8, 0, 5, 8, 1, 3'b001, 0));
        vecs.push_back(mk("irmovq",    3, 0, 0, 0, 64'h42, 5, 0, 64'h42, 5, 0, 3'b001, 0));
        vecs.push_back(mk("mrmovq",    5, 0, 0, 64'h20, 64'h10, 4'hF, 0, 64'h30, 4'hF, 0,
                          3'b001, 0));
        vecs.push_back(mk("mulq_noext", 6, 4, 3, 4, 0, 2, 1, 0, 2, 0, 3'b001, 3));
        vecs.push_back(mk("cmov_if7",  2, 7, 1, 0, 0, 9, 0, 1, 4'hF, 0, 3'b001, 0));
        vecs.push_back(mk("call",      8, 0, 0, 64'h200, 64'h999, 4, 0, 64'h1F8, 4, 0,
                          3'b001, 0));
        vecs.push_back(mk("ret",       9, 0, 0, 64'h200, 0, 4, 0, 64'h208, 4, 0, 3'b001, 0));

        reset = 1'b1; E_stat = 2'd0; E_dstM = 4'h7; M_stall = 1'b0; M_bubble = 1'b0;
        set_e(1, 0, 0, 0, 0, 4'hF, 0);
        tick(); tick();
        check("rst_icode", m_icode64, 1);
        check("rst_dstE", m_dste64, 4'hF);
        check("rst_dstM", m_dstm64, 4'hF);
        check("rst_stat", m_stat64, 0);
        check("rst_cc64", cc64, 3'b100);
        check("rst_cc32", cc32, 3'b100);
        reset = 1'b0;

        foreach (vecs[i]) begin
            set_e(vecs[i].icode, vecs[i].ifun, vecs[i].val_a, vecs[i].val_b, vecs[i].val_c,
                  vecs[i].dst_e, vecs[i].set_cc);
            #1;
            check({vecs[i].name, ".e_valE"}, e_vale64, vecs[i].exp_val_e);
            check({vecs[i].name, ".e_dstE"}, e_dste64, vecs[i].exp_dst_e);
            check({vecs[i].name, ".e_Cnd"}, e_cnd64, vecs[i].exp_cnd);
            tick();
            check({vecs[i].name, ".cc"}, cc64, vecs[i].exp_cc);
            check({vecs[i].name, ".M_icode"}, m_icode64, vecs[i].icode);
            check({vecs[i].name, ".M_valE"}, m_vale64, vecs[i].exp_val_e);
            check({vecs[i].name, ".M_valA"}, m_vala64, vecs[i].val_a);
            check({vecs[i].name, ".M_dstE"}, m_dste64, vecs[i].exp_dst_e);
            check({vecs[i].name, ".M_dstM"}, m_dstm64, 4'h7);
            check({vecs[i].name, ".M_Cnd"}, m_cnd64, vecs[i].exp_cnd);
            check({vecs[i].name, ".M_stat"}, m_stat64, vecs[i].exp_stat);
        end

        // Stall: M holds while E changes; stall+bubble also holds; bubble alone loads NOP.
        set_e(3, 0, 0, 0, 64'hAA, 6, 0);
        tick();
        check("pre_stall.M_valE", m_vale64, 64'hAA);
        M_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_e(6, 0, 64'(k + 1), 64'(k + 2), 0, 4'(k), 0);
            tick();
            check($sformatf("stall%0d.M_icode", k), m_icode64, 3);
            check($sformatf("stall%0d.M_valE", k), m_vale64, 64'hAA);
            check($sformatf("stall%0d.M_dstE", k), m_dste64, 6);
        end
        M_bubble = 1'b1;
        set_e(6, 0, 7, 7, 0, 2, 0);
        tick();
        check("stall_bub.M_icode", m_icode64, 3);
        check("stall_bub.M_valE", m_vale64, 64'hAA);
        M_stall = 1'b0;
        set_e(6, 1, 3, 3, 0, 2, 1);
        tick();
        check("bubble.M_icode", m_icode64, 1);
        check("bubble.M_stat", m_stat64, 0);
        check("bubble.M_dstE", m_dste64, 4'hF);
        check("bubble.M_valE", m_vale64, 0);
        check("bubble.cc", cc64, 3'b100);
        M_bubble = 1'b0;

        // Reset mid-stream with a CC-writing OPq present.
        set_e(6, 0, Q4, Q4, 0, 2, 1);
        tick();
        check("pre_rst.cc", cc64, 3'b011);
        set_e(6, 1, 1, 0, 0, 2, 1);
        reset = 1'b1;
        tick();
        check("mid_rst.M_icode", m_icode64, 1);
        check("mid_rst.M_dstE", m_dste64, 4'hF);
        check("mid_rst.M_valE", m_vale64, 0);
        check("mid_rst.cc", cc64, 3'b100);
        reset = 1'b0;

        // Extended ops on the 32-bit instance; the 64-bit instance treats them as invalid.
        set_e(6, 4, 64'h10000, 64'h10000, 0, 2, 1);
        #1;
        check("mul32.e_valE", e_vale32, 0);
        check("mul64.e_valE", e_vale64, 0);
        tick();
        check("mul32.cc", cc32, 3'b101);
        check("mul32.M_stat", m_stat32, 0);
        check("mul64.M_stat", m_stat64, 3);
        check("mul64.cc", cc64, 3'b100);
        set_e(6, 7, 5, 6, 0, 2, 1);
        #1;
        check("if7_32.e_valE", e_vale32, 0);
        tick();
        check("if7_32.cc", cc32, 3'b101);
        check("if7_32.M_stat", m_stat32, 3);
        E_stat = 2'd2;
        tick();
        check("if7_adr.M_stat", m_stat32, 2);
        E_stat = 2'd0;
        set_e(6, 5, 64'hF0, 64'h0F, 0, 2, 1);
        #1;
        check("or32.e_valE", e_vale32, 32'hFF);
        tick();
        check("or32.cc", cc32, 3'b000);
        check("or64.M_stat", m_stat64, 3);
        set_e(6, 4, 64'hFFFF_FFFF, 5, 0, 2, 1);
        #1;
        check("mulneg32.e_valE", e_vale32, 32'hFFFF_FFFB);
        tick();
        check("mulneg32.cc", cc32, 3'b010);
        set_e(4'hA, 0, 0, 64'h100, 0, 4, 0);
        #1;
        check("push32.e_valE", e_vale32, 32'hF8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
